fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_hold_buf.sv | 37 +++
 rtl/fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

  // Stall-vector geometry; bit STALL_ID freezes the ID-side registers.
  localparam int unsigned STALL_W  = 6;
  localparam int unsigned STALL_ID = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry PC/instruction buffer that parks a fetched word while ID is stalled.
module fetch_hold_buf
  import fetch_unit_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic         clear_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t entry_o,
  output logic         valid_o
);

  fetch_entry_t entry_q;
  logic         valid_q;

  // Clear wins over load so a flush in the same cycle never leaves stale data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      entry_q <= entry_i;
      valid_q <= 1'b1;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign entry_o = entry_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, ID-side output registers.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic [31:0]        pc_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [31:0]        imem_rdata_i,
  output logic [31:0]        id_pc_o,
  output logic [31:0]        id_inst_o,
  output logic               id_valid_o,
  output logic               stallreq_if_o
);

  fetch_state_e state_q;
  logic [31:0]  fpc_q;
  logic [31:0]  id_pc_q;
  logic [31:0]  id_inst_q;
  logic         id_valid_q;

  logic         id_stall;
  logic         wait_hit;
  logic         hold_hit;
  logic         deliver;
  logic         hb_load;
  logic         hb_drain;
  logic         hb_valid;
  fetch_entry_t hb_in;
  fetch_entry_t hb_out;
  logic         unused_stall;

  assign id_stall     = stall_i[STALL_ID];
  assign unused_stall = ^{stall_i[STALL_W-1:STALL_ID+1], stall_i[STALL_ID-1:0]};

  assign wait_hit = (state_q == S_WAIT) && imem_rvalid_i;
  assign hold_hit = (state_q == S_HOLD) && hb_valid;
  assign deliver  = !flush_i && !id_stall && (wait_hit || hold_hit);

  assign hb_load  = wait_hit && id_stall && !flush_i;
  assign hb_drain = hold_hit && deliver;
  assign hb_in    = '{pc: fpc_q, inst: imem_rdata_i};

  fetch_hold_buf u_hold_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (hb_load),
    .drain_i (hb_drain),
    .clear_i (flush_i),
    .entry_i (hb_in),
    .entry_o (hb_out),
    .valid_o (hb_valid)
  );

  assign imem_req_o  = (state_q == S_REQ);
  assign imem_addr_o = pc_i;

  // The PC stage advances only on a delivery or a redirect; IDLE/DRAIN always hold it.
  always_comb begin
    stallreq_if_o = 1'b1;
    if (deliver) begin
      stallreq_if_o = 1'b0;
    end else if (flush_i && (state_q != S_IDLE) && (state_q != S_DRAIN)) begin
      stallreq_if_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      fpc_q      <= '0;
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      if (flush_i) begin
        id_inst_q  <= NOP_INST;
        id_valid_q <= 1'b0;
      end else if (!id_stall) begin
        if (wait_hit) begin
          id_pc_q    <= fpc_q;
          id_inst_q  <= imem_rdata_i;
          id_valid_q <= 1'b1;
        end else if (hold_hit) begin
          id_pc_q    <= hb_out.pc;
          id_inst_q  <= hb_out.inst;
          id_valid_q <= 1'b1;
        end else begin
          id_inst_q  <= NOP_INST;
          id_valid_q <= 1'b0;
        end
      end

      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (imem_gnt_i) begin
            fpc_q   <= pc_i;
            state_q <= flush_i ? S_DRAIN : S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            state_q <= (flush_i || !id_stall) ? S_REQ : S_HOLD;
          end else if (flush_i) begin
            state_q <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (flush_i || !id_stall) begin
            state_q <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid_i) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;

endmodule
